// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared constants, state encoding and buffer entry type for the fetch unit
package fetch_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h8002_0000;
  localparam logic [31:0] NOP_INSN         = 32'h0000_0000;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_DROP = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] insn;
  } buf_entry_t;

endpackage

// File: rtl/fetch_buf.sv
// rtl/fetch_buf.sv - synchronous FIFO of {pc,insn} with flush; head is read straight from storage
module fetch_buf
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       flush,
  input  logic       push,
  input  buf_entry_t push_entry,
  input  logic       pop,
  output logic       empty,
  output logic       full,
  output buf_entry_t head
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  buf_entry_t      mem_q [DEPTH];
  logic [AW-1:0]   rd_ptr_q, wr_ptr_q;
  logic [CW-1:0]   count_q;
  logic            do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(DEPTH));
  assign do_pop  = pop & ~empty;
  // a push into a full buffer is only legal when the head leaves on the same edge
  assign do_push = push & (~full | do_pop);
  assign head    = mem_q[rd_ptr_q];

  always_ff @(posedge clock) begin
    if (reset || flush) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_q + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem_q[wr_ptr_q] <= push_entry;
  end

endmodule

// File: rtl/fetch.sv
// rtl/fetch.sv - single-outstanding instruction fetch with redirect/flush and a small decode buffer
module fetch
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc,
  output logic [31:0] insn,
  output logic        insn_valid
);

  fetch_state_e state_q, state_d;
  logic [31:0]  fpc_q, fpc_d;
  logic [31:0]  last_pc_q;
  logic         handshake, push, pop;
  logic         buf_empty, buf_full;
  buf_entry_t   head, push_entry;

  // nothing is outstanding in REQ, so buffer room alone gates the request
  assign imem_req   = (state_q == S_REQ) & ~buf_full & ~reset;
  assign imem_addr  = fpc_q;
  assign handshake  = imem_req & imem_ready;

  assign insn_valid = ~buf_empty & ~reset;
  assign insn       = insn_valid ? head.insn : NOP_INSN;
  assign pc         = reset ? RESET_PC : (buf_empty ? last_pc_q : head.pc);
  assign pop        = insn_valid & ~stall & ~redirect;

  // fpc already moved past the outstanding request, so its address is fpc-4
  assign push_entry = '{pc: fpc_q - 32'd4, insn: imem_rdata};

  always_comb begin
    state_d = state_q;
    fpc_d   = fpc_q;
    push    = 1'b0;
    case (state_q)
      S_REQ: begin
        if (handshake) state_d = redirect ? S_DROP : S_WAIT;
      end
      S_WAIT: begin
        if (imem_rvalid) begin
          state_d = S_REQ;
          push    = ~redirect;
        end else if (redirect) begin
          state_d = S_DROP;
        end
      end
      S_DROP: begin
        if (imem_rvalid) state_d = S_REQ;
      end
      default: state_d = S_REQ;
    endcase
    if (handshake) fpc_d = fpc_q + 32'd4;
    if (redirect)  fpc_d = redirect_pc;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      // a request still in flight must have its response swallowed
      state_q   <= (state_q != S_REQ && !imem_rvalid) ? S_DROP : S_REQ;
      fpc_q     <= RESET_PC;
      last_pc_q <= RESET_PC;
    end else begin
      state_q   <= state_d;
      fpc_q     <= fpc_d;
      last_pc_q <= pc;
    end
  end

  fetch_buf #(.DEPTH(BUF_DEPTH)) u_buf (
    .clock      (clock),
    .reset      (reset),
    .flush      (redirect),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .empty      (buf_empty),
    .full       (buf_full),
    .head       (head)
  );

endmodule

// File: tb/tb_fetch.sv
// tb/tb_fetch.sv - directed vector table, corner sequences and randomized stream check for fetch
module tb_fetch;

  localparam logic [31:0] RPC = 32'h8002_0000;
  localparam logic [31:0] D   = 32'h2408_0005;

  logic        clock = 1'b0;
  logic        reset, stall, redirect, imem_ready, imem_rvalid;
  logic [31:0] redirect_pc, imem_rdata;
  logic        imem_req, insn_valid;
  logic [31:0] imem_addr, pc, insn;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  fetch dut (
    .clock       (clock),
    .reset       (reset),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ready  (imem_ready),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .pc          (pc),
    .insn        (insn),
    .insn_valid  (insn_valid)
  );

  typedef struct {
    logic        rst, stl, rdr;
    logic [31:0] rpc;
    logic        rdy, rvl;
    logic [31:0] rdata;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_pc, e_insn;
  } vec_t;

  function automatic vec_t mk(input logic rst, stl, rdr, input logic [31:0] rpc_v,
                              input logic rdy, rvl, input logic [31:0] rdata_v,
                              input logic e_req, input logic [31:0] e_addr,
                              input logic e_valid, input logic [31:0] e_pc, e_insn);
    vec_t v;
    v.rst = rst; v.stl = stl; v.rdr = rdr; v.rpc = rpc_v;
    v.rdy = rdy; v.rvl = rvl; v.rdata = rdata_v;
    v.e_req = e_req; v.e_addr = e_addr; v.e_valid = e_valid;
    v.e_pc = e_pc; v.e_insn = e_insn;
    return v;
  endfunction

  function automatic logic [31:0] mix(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step(input vec_t v, input string tag);
    reset = v.rst; stall = v.stl; redirect = v.rdr; redirect_pc = v.rpc;
    imem_ready = v.rdy; imem_rvalid = v.rvl; imem_rdata = v.rdata;
    @(negedge clock);
    chk({tag, ".req"}, 32'(imem_req), 32'(v.e_req));
    if (v.e_req) chk({tag, ".addr"}, imem_addr, v.e_addr);
    chk({tag, ".valid"}, 32'(insn_valid), 32'(v.e_valid));
    chk({tag, ".pc"}, pc, v.e_pc);
    chk({tag, ".insn"}, insn, v.e_insn);
    @(posedge clock); #1;
  endtask

  vec_t tbl[18];

  logic [31:0] exp_f, exp_c, prev_pc, prev_addr, m_addr;
  bit          m_busy, hold, prev_redir;
  int          m_cnt;

  initial begin
    reset = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
    imem_ready = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;

    // startup stream with ready=1 and one-cycle responses, then a long stall with the buffer full
    tbl[0]  = mk(1,0,0,0,1,0,D, 0,0,0,RPC,0);
    tbl[1]  = mk(0,0,0,0,1,0,D, 1,RPC,0,RPC,0);
    tbl[2]  = mk(0,0,0,0,1,1,D, 0,0,0,RPC,0);
    tbl[3]  = mk(0,0,0,0,1,0,D, 1,RPC+4,1,RPC,D);
    tbl[4]  = mk(0,0,0,0,1,1,D, 0,0,0,RPC,0);
    tbl[5]  = mk(0,0,0,0,1,0,D, 1,RPC+8,1,RPC+4,D);
    tbl[6]  = mk(0,1,0,0,1,1,D, 0,0,0,RPC+4,0);
    tbl[7]  = mk(0,1,0,0,1,0,D, 1,RPC+12,1,RPC+8,D);
    tbl[8]  = mk(0,1,0,0,1,1,D, 0,0,1,RPC+8,D);
    for (int i = 9; i < 14; i++) tbl[i] = mk(0,1,0,0,1,0,D, 0,0,1,RPC+8,D);
    tbl[14] = mk(0,0,0,0,1,0,D, 0,0,1,RPC+8,D);
    tbl[15] = mk(0,0,0,0,1,0,D, 1,RPC+16,1,RPC+12,D);
    tbl[16] = mk(0,0,0,0,1,1,D, 0,0,0,RPC+12,0);
    tbl[17] = mk(0,0,0,0,0,0,D, 1,RPC+20,1,RPC+16,D);

    @(posedge clock); #1;
    for (int i = 0; i < 18; i++) step(tbl[i], $sformatf("tbl%0d", i));

    // redirect while waiting; the late response must be dropped
    step(mk(1,0,0,0,1,0,0, 0,0,0,RPC,0), "rd0");
    step(mk(0,0,0,0,1,0,0, 1,RPC,0,RPC,0), "rd1");
    step(mk(0,0,1,RPC+32'h100,1,0,0, 0,0,0,RPC,0), "rd2");
    step(mk(0,0,0,0,1,0,0, 0,0,0,RPC,0), "rd3");
    step(mk(0,0,0,0,1,1,32'hDEAD_BEEF, 0,0,0,RPC,0), "rd4");
    step(mk(0,0,0,0,1,0,0, 1,RPC+32'h100,0,RPC,0), "rd5");
    step(mk(0,0,0,0,1,1,32'h1111_1111, 0,0,0,RPC,0), "rd6");
    step(mk(0,0,0,0,0,0,0, 1,RPC+32'h104,1,RPC+32'h100,32'h1111_1111), "rd7");
    // ready held low: request must stay put
    step(mk(0,0,0,0,0,0,0, 1,RPC+32'h104,0,RPC+32'h100,0), "rdy0");
    step(mk(0,0,0,0,0,0,0, 1,RPC+32'h104,0,RPC+32'h100,0), "rdy1");
    step(mk(0,0,0,0,1,0,0, 1,RPC+32'h104,0,RPC+32'h100,0), "rdy2");
    step(mk(0,0,0,0,1,1,32'h2222_2222, 0,0,0,RPC+32'h100,0), "rdy3");
    // redirect coinciding with rvalid under stall flushes everything; then wrap past 2^32
    step(mk(0,1,0,0,1,0,0, 1,RPC+32'h108,1,RPC+32'h104,32'h2222_2222), "rv0");
    step(mk(0,1,1,32'hFFFF_FFFC,1,1,32'h6666_6666, 0,0,1,RPC+32'h104,32'h2222_2222), "rv1");
    step(mk(0,1,0,0,1,0,0, 1,32'hFFFF_FFFC,0,RPC+32'h104,0), "rv2");
    step(mk(0,0,0,0,1,1,32'h3333_3333, 0,0,0,RPC+32'h104,0), "wrap0");
    step(mk(0,0,0,0,1,0,0, 1,32'h0000_0000,1,32'hFFFF_FFFC,32'h3333_3333), "wrap1");
    // reset while a request is in flight; its late response must be ignored
    step(mk(1,0,0,0,1,0,0, 0,0,0,RPC,0), "rs0");
    step(mk(0,0,0,0,1,0,0, 0,0,0,RPC,0), "rs1");
    step(mk(0,0,0,0,1,1,32'h4444_4444, 0,0,0,RPC,0), "rs2");
    step(mk(0,0,0,0,1,0,0, 1,RPC,0,RPC,0), "rs3");
    step(mk(0,0,0,0,1,1,32'h5555_5555, 0,0,0,RPC,0), "rs4");
    step(mk(0,0,0,0,0,0,0, 1,RPC+4,1,RPC,32'h5555_5555), "rs5");

    // randomized traffic against a stream-level model of fetch and consume order
    m_busy = 0; m_cnt = 0; m_addr = '0; hold = 0; prev_redir = 0;
    exp_f = RPC; exp_c = RPC; prev_pc = RPC; prev_addr = '0;
    for (int n = 0; n < 3000; n++) begin
      bit r_rst, r_stall, r_redir, r_ready, r_rvalid;
      logic [31:0] r_rpc;
      r_rst    = (n == 0) || ($urandom_range(0, 199) == 0);
      r_stall  = ($urandom_range(0, 3) == 0);
      r_redir  = ($urandom_range(0, 15) == 0);
      r_rpc    = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 + 32'($urandom_range(0, 3)) * 32'd4)
                                              : ($urandom & 32'hFFFF_FFFC);
      r_ready  = ($urandom_range(0, 2) != 0);
      r_rvalid = m_busy && (m_cnt == 0);
      reset = r_rst; stall = r_stall; redirect = r_redir; redirect_pc = r_rpc;
      imem_ready = r_ready; imem_rvalid = r_rvalid;
      imem_rdata = r_rvalid ? mix(m_addr) : $urandom;
      @(negedge clock);
      if (r_rst) begin
        chk("rnd.rst_req", 32'(imem_req), 0);
        chk("rnd.rst_valid", 32'(insn_valid), 0);
        chk("rnd.rst_pc", pc, RPC);
        chk("rnd.rst_insn", insn, 0);
      end else begin
        if (imem_req) begin
          chk("rnd.one_outstanding", 32'(m_busy), 0);
          chk("rnd.req_addr", imem_addr, exp_f);
        end
        if (hold) begin
          chk("rnd.req_hold", 32'(imem_req), 1);
          chk("rnd.addr_hold", imem_addr, prev_addr);
        end
        if (prev_redir) chk("rnd.post_redirect_valid", 32'(insn_valid), 0);
        if (insn_valid) begin
          chk("rnd.pc_stream", pc, exp_c);
          chk("rnd.insn_stream", insn, mix(exp_c));
        end else begin
          chk("rnd.nop", insn, 0);
          chk("rnd.pc_hold", pc, prev_pc);
        end
      end
      hold      = !r_rst && imem_req && !r_ready && !r_redir;
      prev_addr = imem_addr;
      if (r_rvalid) m_busy = 0;
      else if (m_busy) m_cnt--;
      if (r_rst) begin
        exp_f = RPC; exp_c = RPC; prev_pc = RPC;
      end else begin
        if (imem_req && r_ready) begin
          m_busy = 1; m_cnt = $urandom_range(0, 2); m_addr = exp_f;
        end
        if (r_redir) exp_f = r_rpc;
        else if (imem_req && r_ready) exp_f = exp_f + 32'd4;
        if (r_redir) exp_c = r_rpc;
        else if (insn_valid && !r_stall) exp_c = exp_c + 32'd4;
        prev_pc = pc;
      end
      prev_redir = r_redir && !r_rst;
      @(posedge clock); #1;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch.md
FETCH -- requirements
Module: fetch

Interface
REQ-001 Parameter RESET_PC, 32'h8002_0000, PC loaded on reset.
REQ-002 Parameter BUF_DEPTH, 2, instruction buffer entries (power of two, >=2).
REQ-003 clock  in  1  sole clock; all state updates on rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 stall  in  1  decode cannot accept; hold pc/insn outputs.
REQ-006 redirect  in  1  branch/jump taken; flush and refetch from redirect_pc.
REQ-007 redirect_pc  in  32  target address, word-aligned.
REQ-008 imem_req  out  1  request valid to instruction memory.
REQ-009 imem_addr  out  32  request address.
REQ-010 imem_ready  in  1  memory accepts request this cycle (req & ready = handshake).
REQ-011 imem_rvalid  in  1  response data valid.
REQ-012 imem_rdata  in  32  response instruction word.
REQ-013 pc  out  32  PC of presented instruction.
REQ-014 insn  out  32  presented instruction; 32'h0 (NOP) when insn_valid=0.
REQ-015 insn_valid  out  1  insn/pc hold a real instruction.

Function
REQ-016 Fetch PC (fpc) SHALL advance by 4 on each accepted request; no other increment.
REQ-017 At most one request SHALL be outstanding; imem_req asserted only in state REQ.
REQ-018 imem_req SHALL assert only when buffer occupancy + outstanding < BUF_DEPTH; imem_addr = fpc; req/addr held stable until imem_ready.
REQ-019 States: REQ (issue), WAIT (awaiting rvalid), DROP (awaiting rvalid of squashed request).
REQ-020 Transitions: REQ->WAIT on req&ready; WAIT->REQ on rvalid; WAIT->DROP on redirect without same-cycle rvalid; DROP->REQ on rvalid.
REQ-021 Response in WAIT SHALL be written to buffer with its request address; response in DROP SHALL be discarded.
REQ-022 Buffer head SHALL drive pc/insn/insn_valid combinationally from registered storage; pops when insn_valid & ~stall.
REQ-023 Buffer empty: insn_valid=0, insn=32'h0, pc = last presented pc.
REQ-024 Buffer full: no new request issued; simultaneous push and pop when full SHALL be legal only if pop occurs (occupancy unchanged).
REQ-025 Empty buffer with same-cycle rvalid: data appears on insn the following cycle (fetch-to-decode latency 1 cycle after rvalid).
REQ-026 redirect SHALL flush buffer same edge, set fpc=redirect_pc, override stall; next cycle insn_valid=0.
REQ-027 redirect in REQ with same-cycle imem_ready: request squashed, state->DROP.
REQ-028 redirect in WAIT with same-cycle rvalid: response discarded, state->REQ.
REQ-029 redirect has priority over stall, push and pop.
REQ-030 fpc SHALL wrap modulo 2^32 without error.

Reset
REQ-031 reset SHALL set fpc=RESET_PC, state=REQ, buffer empty, pc=RESET_PC, insn=32'h0, insn_valid=0, imem_req=0 in the reset cycle.
REQ-032 reset asserted mid-WAIT: pending response SHALL be ignored (state DROP after reset if request in flight, else REQ).
REQ-033 First request SHALL issue in the cycle after reset deasserts with imem_addr=RESET_PC.

Structure
REQ-034 Shared package holds RESET_PC default, NOP word 32'h0, state encodings.
REQ-035 Buffer implemented as sub-module fetch_buf (synchronous FIFO storing {pc,insn}, flush input).

Verification
REQ-036 Reset, ready=1, 1-cycle rvalid, rdata=0x24080005 -> imem_addr 0x80020000,04,08...; insn=0x24080005 pc=0x80020000 valid 2 cycles after reset release.
REQ-037 stall held 5 cycles with buffer full -> imem_req=0, pc/insn constant; release -> sequential pcs, none lost or duplicated.
REQ-038 redirect to 0x80020100 while WAIT, rvalid 2 cycles later -> that response dropped; next imem_addr=0x80020100, first valid pc=0x80020100.
REQ-039 redirect same cycle as rvalid with stall=1 -> buffer empty next cycle, insn=0, valid=0.
REQ-040 imem_ready low 3 cycles -> imem_req/imem_addr stable; fpc=0xFFFFFFFC accepted -> next addr 0x00000000.
REQ-041 reset pulsed during WAIT -> stale rvalid ignored, first valid pc=RESET_PC.
